// File: rtl/wb_pkg.sv
// Shared types and default sizes for the writeback arbiter and its load FIFO.
package wb_pkg;

    localparam int WB_W     = 8;
    localparam int WB_D     = 4;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic              valid;
        logic [WB_D-1:0]   waddr;
        logic [WB_W-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between execute/memory, decode and the register-file write port.
// The byp_* signals exist only when WB_BYPASS_EN is defined.
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int W     = WB_W,
    parameter int D     = WB_D,
    parameter int DEPTH = WB_DEPTH
) ();

    logic                      alu_valid;
    logic [D-1:0]              alu_waddr;
    logic [W-1:0]              alu_data;

    logic                      mem_valid;
    logic                      mem_ready;
    logic [D-1:0]              mem_waddr;
    logic [W-1:0]              mem_data;

    logic                      write_en;
    logic [D-1:0]              waddr;
    logic [W-1:0]              data_in;

    logic [D-1:0]              chk_addrA;
    logic [D-1:0]              chk_addrB;
    logic                      hazardA;
    logic                      hazardB;

    logic [cnt_w(DEPTH)-1:0]   fifo_count;

`ifdef WB_BYPASS_EN
    logic                      byp_validA;
    logic                      byp_validB;
    logic [W-1:0]              byp_dataA;
    logic [W-1:0]              byp_dataB;
`endif

    // Upstream/decode side.
    modport master (
        output alu_valid, alu_waddr, alu_data,
        output mem_valid, mem_waddr, mem_data,
        output chk_addrA, chk_addrB,
        input  mem_ready, write_en, waddr, data_in,
        input  hazardA, hazardB, fifo_count
`ifdef WB_BYPASS_EN
        ,
        input  byp_validA, byp_validB, byp_dataA, byp_dataB
`endif
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_waddr, alu_data,
        input  mem_valid, mem_waddr, mem_data,
        input  chk_addrA, chk_addrB,
        output mem_ready, write_en, waddr, data_in,
        output hazardA, hazardB, fifo_count
`ifdef WB_BYPASS_EN
        ,
        output byp_validA, byp_validB, byp_dataA, byp_dataB
`endif
    );

endinterface

// File: rtl/wb_fifo.sv
// Load-result FIFO with per-entry valid bits, squash-by-address and
// combinational match-by-address lookups for hazard detection.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int W     = WB_W,
    parameter int D     = WB_D,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [D-1:0]            i_push_waddr,
    input  logic [W-1:0]            i_push_data,
    input  logic                    i_pop,
    input  logic                    i_squash_en,
    input  logic [D-1:0]            i_squash_addr,
    input  logic [D-1:0]            i_chk_a,
    input  logic [D-1:0]            i_chk_b,
    output logic                    o_match_a,
    output logic                    o_match_b,
    output logic                    o_head_valid,
    output logic [D-1:0]            o_head_waddr,
    output logic [W-1:0]            o_head_data,
    output logic [cnt_w(DEPTH)-1:0] o_count,
    output logic                    o_empty,
    output logic                    o_full
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] r_valid;
    logic [D-1:0]     r_waddr [DEPTH];
    logic [W-1:0]     r_data  [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_match_a;
    logic             w_match_b;

    // Squash, pop-clear and push-set touch valid bits in that order; the push
    // slot is always free, so a load pushed alongside an ALU squash survives.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_squash_en && (r_waddr[i] == i_squash_addr)) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (i_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            if (i_push) begin
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; the valid bits alone define occupancy.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_waddr[r_wptr] <= i_push_waddr;
            r_data[r_wptr]  <= i_push_data;
        end
    end

    always_comb begin
        w_match_a = 1'b0;
        w_match_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_waddr[i] == i_chk_a)) w_match_a = 1'b1;
            if (r_valid[i] && (r_waddr[i] == i_chk_b)) w_match_b = 1'b1;
        end
    end

    assign o_match_a    = w_match_a;
    assign o_match_b    = w_match_b;
    assign o_head_valid = r_valid[r_rptr];
    assign o_head_waddr = r_waddr[r_rptr];
    assign o_head_data  = r_data[r_rptr];
    assign o_count      = r_count;
    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == FULL_CNT);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take priority over buffered loads into the
// registered reg-file write port. WB_BYPASS_EN adds decode bypass outputs.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int W     = WB_W,
    parameter int D     = WB_D,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic         CLK,
    input  logic         RESET_N,
    wb_arbiter_if.slave  bus
);

    wb_src_e                   w_src;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_squash;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_head_valid;
    logic [D-1:0]              w_head_waddr;
    logic [W-1:0]              w_head_data;
    logic                      w_match_a;
    logic                      w_match_b;
    logic                      w_out_hit_a;
    logic                      w_out_hit_b;
    logic                      w_chk_nz_a;
    logic                      w_chk_nz_b;
    logic [cnt_w(DEPTH)-1:0]   w_count;

    logic                      r_we;
    logic [D-1:0]              r_waddr;
    logic [W-1:0]              r_data;

    // Ready looks at the current count only, so a full FIFO refuses a load
    // even in a cycle where it also pops.
    assign bus.mem_ready = !w_full;
    assign w_push        = bus.mem_valid && !w_full && (bus.mem_waddr != '0);
    assign w_squash      = bus.alu_valid && (bus.alu_waddr != '0);
    assign w_pop         = (w_src == SRC_FIFO);

    always_comb begin
        w_src = SRC_NONE;
        if (bus.alu_valid) begin
            w_src = SRC_ALU;
        end else if (!w_empty) begin
            w_src = SRC_FIFO;
        end
    end

    wb_fifo #(
        .W     (W),
        .D     (D),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk         (CLK),
        .i_rst_n       (RESET_N),
        .i_push        (w_push),
        .i_push_waddr  (bus.mem_waddr),
        .i_push_data   (bus.mem_data),
        .i_pop         (w_pop),
        .i_squash_en   (w_squash),
        .i_squash_addr (bus.alu_waddr),
        .i_chk_a       (bus.chk_addrA),
        .i_chk_b       (bus.chk_addrB),
        .o_match_a     (w_match_a),
        .o_match_b     (w_match_b),
        .o_head_valid  (w_head_valid),
        .o_head_waddr  (w_head_waddr),
        .o_head_data   (w_head_data),
        .o_count       (w_count),
        .o_empty       (w_empty),
        .o_full        (w_full)
    );

    // A squashed head still pops, giving a write_en=0 slot in load order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_data  <= '0;
        end else begin
            case (w_src)
                SRC_ALU: begin
                    r_we    <= (bus.alu_waddr != '0);
                    r_waddr <= bus.alu_waddr;
                    r_data  <= bus.alu_data;
                end
                SRC_FIFO: begin
                    r_we    <= w_head_valid;
                    r_waddr <= w_head_waddr;
                    r_data  <= w_head_data;
                end
                default: begin
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.write_en   = r_we;
    assign bus.waddr      = r_waddr;
    assign bus.data_in    = r_data;
    assign bus.fifo_count = w_count;

    assign w_chk_nz_a  = (bus.chk_addrA != '0);
    assign w_chk_nz_b  = (bus.chk_addrB != '0);
    assign w_out_hit_a = r_we && (r_waddr == bus.chk_addrA);
    assign w_out_hit_b = r_we && (r_waddr == bus.chk_addrB);

`ifdef WB_BYPASS_EN
    // The output register is forwarded to decode, so only queued loads stall.
    assign bus.hazardA    = w_chk_nz_a && w_match_a;
    assign bus.hazardB    = w_chk_nz_b && w_match_b;
    assign bus.byp_validA = w_chk_nz_a && w_out_hit_a;
    assign bus.byp_validB = w_chk_nz_b && w_out_hit_b;
    assign bus.byp_dataA  = r_data;
    assign bus.byp_dataB  = r_data;
`else
    assign bus.hazardA    = w_chk_nz_a && (w_match_a || w_out_hit_a);
    assign bus.hazardB    = w_chk_nz_b && (w_match_b || w_out_hit_b);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; checks the bypass outputs too
// when WB_BYPASS_EN is defined.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int W     = 8;
    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 CLK = ~CLK;

    wb_arbiter_if #(.W(W), .D(D), .DEPTH(DEPTH)) bus ();

    wb_arbiter #(.W(W), .D(D), .DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_waddr = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_data  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.chk_addrA = 4'd3;
        bus.chk_addrB = 4'd5;
        RESET_N = 1'b0;
        #2;
        checks++; if (bus.write_en !== 1'b0) begin errors++; $display("FAIL rst_we: got %0d want 0", bus.write_en); end
        checks++; if (bus.waddr !== 4'd0) begin errors++; $display("FAIL rst_waddr: got %0d want 0", bus.waddr); end
        checks++; if (bus.data_in !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h want 0", bus.data_in); end
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0d want 1", bus.mem_ready); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.fifo_count); end
        checks++; if (bus.hazardA !== 1'b0 || bus.hazardB !== 1'b0) begin errors++; $display("FAIL rst_hazard: got %0d%0d want 00", bus.hazardA, bus.hazardB); end
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        bus.alu_valid = 1'b1; bus.alu_waddr = 4'd3; bus.alu_data = 8'h5A;
        tick();
        checks++; if (bus.write_en !== 1'b1) begin errors++; $display("FAIL alu_we: got %0d want 1", bus.write_en); end
        checks++; if (bus.waddr !== 4'd3) begin errors++; $display("FAIL alu_waddr: got %0d want 3", bus.waddr); end
        checks++; if (bus.data_in !== 8'h5A) begin errors++; $display("FAIL alu_data: got %0h want 5a", bus.data_in); end
        bus.alu_waddr = 4'd0; bus.alu_data = 8'h11;
        tick();
        checks++; if (bus.write_en !== 1'b0) begin errors++; $display("FAIL alu_r0_we: got %0d want 0", bus.write_en); end
        bus.alu_valid = 1'b0;
        tick();
        checks++; if (bus.write_en !== 1'b0 || bus.waddr !== 4'd0) begin errors++; $display("FAIL idle_hold: got we=%0d waddr=%0d want 0/0", bus.write_en, bus.waddr); end
    endtask

    task automatic test_loads();
        bus.mem_valid = 1'b1; bus.mem_waddr = 4'd0; bus.mem_data = 8'hEE;
        tick();
        checks++; if (bus.fifo_count !== 3'd0 || bus.write_en !== 1'b0) begin errors++; $display("FAIL discard_r0: got cnt=%0d we=%0d want 0/0", bus.fifo_count, bus.write_en); end
        // Hold the FIFO with ALU writes to r0 so it fills up.
        bus.alu_valid = 1'b1; bus.alu_waddr = 4'd0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_waddr = D'(i + 1); bus.mem_data = W'(8'h10 + i);
            tick();
            checks++; if (bus.fifo_count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count%0d: got %0d want %0d", i, bus.fifo_count, i + 1); end
        end
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0d want 0", bus.mem_ready); end
        bus.chk_addrA = 4'd2;
        #1;
        checks++; if (bus.hazardA !== 1'b1) begin errors++; $display("FAIL fill_hazard: got %0d want 1", bus.hazardA); end
        bus.mem_waddr = 4'd5; bus.mem_data = 8'h14;
        tick();
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_reject: got %0d want 4", bus.fifo_count); end
        // Pop while full: the offered load must still be refused.
        bus.alu_valid = 1'b0;
        tick();
        bus.mem_valid = 1'b0;
        checks++; if (bus.write_en !== 1'b1 || bus.waddr !== 4'd1 || bus.data_in !== 8'h10) begin errors++; $display("FAIL drain0: got we=%0d waddr=%0d data=%0h want 1/1/10", bus.write_en, bus.waddr, bus.data_in); end
        checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop_count: got %0d want 3", bus.fifo_count); end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (bus.write_en !== 1'b1 || bus.waddr !== D'(i + 1) || bus.data_in !== W'(8'h10 + i)) begin errors++; $display("FAIL drain%0d: got we=%0d waddr=%0d data=%0h want 1/%0d/%0h", i, bus.write_en, bus.waddr, bus.data_in, i + 1, 8'h10 + i); end
            checks++; if (bus.fifo_count !== 3'(3 - i)) begin errors++; $display("FAIL drain_count%0d: got %0d want %0d", i, bus.fifo_count, 3 - i); end
        end
        tick();
        checks++; if (bus.write_en !== 1'b0 || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL drained: got we=%0d ready=%0d want 0/1", bus.write_en, bus.mem_ready); end
        bus.chk_addrA = 4'd0;
    endtask

    task automatic test_squash();
        bus.alu_valid = 1'b1; bus.alu_waddr = 4'd0;
        bus.mem_valid = 1'b1; bus.mem_waddr = 4'd5; bus.mem_data = 8'hAA;
        tick();
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL sq_push: got %0d want 1", bus.fifo_count); end
        // ALU write to r5 squashes the queued load; the same-cycle load survives.
        bus.alu_waddr = 4'd5; bus.alu_data = 8'hBB;
        bus.mem_waddr = 4'd5; bus.mem_data = 8'hCC;
        tick();
        idle_inputs();
        checks++; if (bus.write_en !== 1'b1 || bus.waddr !== 4'd5 || bus.data_in !== 8'hBB) begin errors++; $display("FAIL sq_alu: got we=%0d waddr=%0d data=%0h want 1/5/bb", bus.write_en, bus.waddr, bus.data_in); end
        checks++; if (bus.fifo_count !== 3'd2) begin errors++; $display("FAIL sq_count: got %0d want 2", bus.fifo_count); end
        tick();
        checks++; if (bus.write_en !== 1'b0 || bus.fifo_count !== 3'd1) begin errors++; $display("FAIL sq_bubble: got we=%0d cnt=%0d want 0/1", bus.write_en, bus.fifo_count); end
        tick();
        checks++; if (bus.write_en !== 1'b1 || bus.waddr !== 4'd5 || bus.data_in !== 8'hCC) begin errors++; $display("FAIL sq_young: got we=%0d waddr=%0d data=%0h want 1/5/cc", bus.write_en, bus.waddr, bus.data_in); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL sq_empty: got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_hazard();
        bus.chk_addrA = 4'd6; bus.chk_addrB = 4'd7;
        bus.alu_valid = 1'b1; bus.alu_waddr = 4'd0;
        bus.mem_valid = 1'b1; bus.mem_waddr = 4'd6; bus.mem_data = 8'h77;
        #1;
        checks++; if (bus.hazardA !== 1'b0) begin errors++; $display("FAIL hz_before: got %0d want 0", bus.hazardA); end
        tick();
        bus.mem_valid = 1'b0;
        checks++; if (bus.hazardA !== 1'b1 || bus.hazardB !== 1'b0) begin errors++; $display("FAIL hz_queued: got A=%0d B=%0d want 1/0", bus.hazardA, bus.hazardB); end
        tick();
        checks++; if (bus.hazardA !== 1'b1) begin errors++; $display("FAIL hz_hold: got %0d want 1", bus.hazardA); end
        bus.alu_valid = 1'b0;
        tick();
        checks++; if (bus.write_en !== 1'b1 || bus.waddr !== 4'd6 || bus.data_in !== 8'h77) begin errors++; $display("FAIL hz_pop: got we=%0d waddr=%0d data=%0h want 1/6/77", bus.write_en, bus.waddr, bus.data_in); end
`ifdef WB_BYPASS_EN
        checks++; if (bus.hazardA !== 1'b0) begin errors++; $display("FAIL hz_out_byp: got %0d want 0", bus.hazardA); end
        checks++; if (bus.byp_validA !== 1'b1 || bus.byp_dataA !== 8'h77) begin errors++; $display("FAIL byp_a: got v=%0d d=%0h want 1/77", bus.byp_validA, bus.byp_dataA); end
        checks++; if (bus.byp_validB !== 1'b0) begin errors++; $display("FAIL byp_b: got %0d want 0", bus.byp_validB); end
`else
        checks++; if (bus.hazardA !== 1'b1) begin errors++; $display("FAIL hz_out: got %0d want 1", bus.hazardA); end
`endif
        tick();
        checks++; if (bus.write_en !== 1'b0 || bus.hazardA !== 1'b0) begin errors++; $display("FAIL hz_clear: got we=%0d A=%0d want 0/0", bus.write_en, bus.hazardA); end
        bus.chk_addrA = 4'd0; bus.chk_addrB = 4'd0;
    endtask

    task automatic test_wrap();
        wb_entry_t exp_q [12];
        for (int k = 0; k < 12; k++) begin
            exp_q[k].valid = 1'b1;
            exp_q[k].waddr = D'((k % 7) + 1);
            exp_q[k].data  = W'(8'h30 + k);
        end
        for (int k = 0; k < 12; k++) begin
            bus.mem_valid = 1'b1; bus.mem_waddr = exp_q[k].waddr; bus.mem_data = exp_q[k].data;
            tick();
            checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL wrap_count%0d: got %0d want 1", k, bus.fifo_count); end
            if (k > 0) begin
                checks++; if (bus.write_en !== 1'b1 || bus.waddr !== exp_q[k-1].waddr || bus.data_in !== exp_q[k-1].data) begin errors++; $display("FAIL wrap_out%0d: got we=%0d waddr=%0d data=%0h want 1/%0d/%0h", k - 1, bus.write_en, bus.waddr, bus.data_in, exp_q[k-1].waddr, exp_q[k-1].data); end
            end
        end
        bus.mem_valid = 1'b0;
        tick();
        checks++; if (bus.write_en !== 1'b1 || bus.waddr !== exp_q[11].waddr || bus.data_in !== exp_q[11].data) begin errors++; $display("FAIL wrap_last: got we=%0d waddr=%0d data=%0h want 1/%0d/%0h", bus.write_en, bus.waddr, bus.data_in, exp_q[11].waddr, exp_q[11].data); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL wrap_empty: got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_reset_mid();
        bus.alu_valid = 1'b1; bus.alu_waddr = 4'd0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_valid = 1'b1; bus.mem_waddr = D'(i + 1); bus.mem_data = W'(8'h41 + i);
            tick();
        end
        bus.mem_valid = 1'b0;
        bus.alu_waddr = 4'd9; bus.alu_data = 8'h99;
        bus.chk_addrA = 4'd2;
        tick();
        checks++; if (bus.fifo_count !== 3'd3 || bus.write_en !== 1'b1 || bus.waddr !== 4'd9) begin errors++; $display("FAIL pre_rst: got cnt=%0d we=%0d waddr=%0d want 3/1/9", bus.fifo_count, bus.write_en, bus.waddr); end
        checks++; if (bus.hazardA !== 1'b1) begin errors++; $display("FAIL pre_rst_hz: got %0d want 1", bus.hazardA); end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++; if (bus.write_en !== 1'b0 || bus.waddr !== 4'd0 || bus.data_in !== 8'h00) begin errors++; $display("FAIL mid_rst_out: got we=%0d waddr=%0d data=%0h want 0/0/0", bus.write_en, bus.waddr, bus.data_in); end
        checks++; if (bus.fifo_count !== 3'd0 || bus.mem_ready !== 1'b1 || bus.hazardA !== 1'b0) begin errors++; $display("FAIL mid_rst_fifo: got cnt=%0d ready=%0d hz=%0d want 0/1/0", bus.fifo_count, bus.mem_ready, bus.hazardA); end
        idle_inputs();
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.write_en !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL post_rst%0d: got we=%0d cnt=%0d want 0/0", i, bus.write_en, bus.fifo_count); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_squash();
        test_hazard();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
